// File: rtl/wcc_frame_sched_pkg.sv
// rtl/wcc_frame_sched_pkg.sv - shared state encoding and gain constants for the frame scheduler
package wcc_frame_sched_pkg;

    localparam int GAIN_W = 4;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd15;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FADE_IN  = 3'd1;
    localparam state_t ST_RUN      = 3'd2;
    localparam state_t ST_FADE_OUT = 3'd3;
    localparam state_t ST_SWITCH   = 3'd4;

    // States in which the picture is visible and the pattern phase advances
    function automatic logic state_active(input state_t s);
        return (s == ST_FADE_IN) || (s == ST_RUN) || (s == ST_FADE_OUT);
    endfunction

endpackage

// File: rtl/wcc_frame_tick.sv
// rtl/wcc_frame_tick.sv - VSync rising-edge detector qualified by the pixel enable
module wcc_frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_pix,
    input  logic vsync,
    output logic frame_tick
);

    logic vs_q;
    logic vs_d;

    always_comb begin
        vs_d = vs_q;
        if (ce_pix) begin
            vs_d = vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign frame_tick = ce_pix & vsync & ~vs_q;

endmodule

// File: rtl/wcc_frame_sched.sv
// rtl/wcc_frame_sched.sv - frame-synchronous fade/run/mode-switch scheduler for the pattern generator
module wcc_frame_sched
    import wcc_frame_sched_pkg::*;
#(
    parameter int FADE_FRAMES   = 4,
    parameter int SETTLE_FRAMES = 2,
    parameter int PHASE_STEP    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              VSync,
    input  logic              start,
    input  logic              stop,
    input  logic              pal_req,
    input  logic              scandouble_req,
    output logic              pal,
    output logic              scandouble,
    output logic [9:0]        phase,
    output logic [GAIN_W-1:0] gain,
    output logic              video_en,
    output logic              busy
);

    localparam logic [7:0] FADE_LAST   = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
    localparam logic [9:0] PHASE_INC   = 10'(PHASE_STEP);

    logic frame_tick;

    state_t            state_q, state_d;
    logic              to_switch_q, to_switch_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [9:0]        phase_q, phase_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pal_q, pal_d;
    logic              sd_q, sd_d;
    logic              init_q, init_d;
    logic              keep_switch;

    wcc_frame_tick u_frame_tick (
        .clk        (clk),
        .rst_n      (reset),
        .ce_pix     (ce_pix),
        .vsync      (VSync),
        .frame_tick (frame_tick)
    );

    always_comb begin
        state_d     = state_q;
        to_switch_d = to_switch_q;
        gain_d      = gain_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        pal_d       = pal_q;
        sd_d        = sd_q;
        init_d      = 1'b1;
        keep_switch = to_switch_q & ~stop;

        // Applied mode follows the requests once, on the first clock after reset release
        if (!init_q) begin
            pal_d = pal_req;
            sd_d  = scandouble_req;
        end

        if (frame_tick) begin
            if (state_active(state_q)) begin
                phase_d = phase_q + PHASE_INC;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = ST_FADE_IN;
                        cnt_d   = 8'd0;
                    end
                end
                ST_FADE_IN: begin
                    if (stop) begin
                        state_d     = ST_FADE_OUT;
                        to_switch_d = 1'b0;
                        cnt_d       = 8'd0;
                    end else if (gain_q == GAIN_MAX) begin
                        state_d = ST_RUN;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == FADE_LAST) begin
                        gain_d = gain_q + 1'b1;
                        cnt_d  = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d     = ST_FADE_OUT;
                        to_switch_d = 1'b0;
                        cnt_d       = 8'd0;
                    end else if ({pal_req, scandouble_req} != {pal_q, sd_q}) begin
                        state_d     = ST_FADE_OUT;
                        to_switch_d = 1'b1;
                        cnt_d       = 8'd0;
                    end
                end
                ST_FADE_OUT: begin
                    to_switch_d = keep_switch;
                    if (gain_q == '0) begin
                        cnt_d = 8'd0;
                        if (keep_switch) begin
                            state_d = ST_SWITCH;
                            pal_d   = pal_req;
                            sd_d    = scandouble_req;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (cnt_q == FADE_LAST) begin
                        gain_d = gain_q - 1'b1;
                        cnt_d  = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SWITCH: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_FADE_IN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gain_d  = '0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            to_switch_q <= 1'b0;
            gain_q      <= '0;
            phase_q     <= 10'd0;
            cnt_q       <= 8'd0;
            pal_q       <= 1'b0;
            sd_q        <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_switch_q <= to_switch_d;
            gain_q      <= gain_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            pal_q       <= pal_d;
            sd_q        <= sd_d;
            init_q      <= init_d;
        end
    end

    assign pal        = pal_q;
    assign scandouble = sd_q;
    assign phase      = phase_q;
    assign gain       = gain_q;
    assign video_en   = state_active(state_q);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);

endmodule

// File: tb/tb_wcc_frame_sched.sv
// tb/tb_wcc_frame_sched.sv - scoreboard bench for the frame scheduler
module tb_wcc_frame_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       VSync;
    logic       start;
    logic       stop;
    logic       pal_req;
    logic       scandouble_req;
    logic       pal;
    logic       scandouble;
    logic [9:0] phase;
    logic [3:0] gain;
    logic       video_en;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] gain;
        logic [9:0] phase;
        logic       ven;
        logic       busy;
        logic       pal;
        logic       sd;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] exp_phase;
    logic       exp_pal;
    logic       exp_sd;

    always #5 clk = ~clk;

    wcc_frame_sched #(
        .FADE_FRAMES   (4),
        .SETTLE_FRAMES (2),
        .PHASE_STEP    (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ce_pix         (ce_pix),
        .VSync          (VSync),
        .start          (start),
        .stop           (stop),
        .pal_req        (pal_req),
        .scandouble_req (scandouble_req),
        .pal            (pal),
        .scandouble     (scandouble),
        .phase          (phase),
        .gain           (gain),
        .video_en       (video_en),
        .busy           (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk);
        ce_pix = 1'b1;
        VSync  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        VSync = 1'b0;
        @(negedge clk);
    endtask

    // One frame: adv says whether the pre-tick state advances the phase
    task automatic expect_frame(input string tag, input logic adv, input logic [3:0] g,
                                input logic ven, input logic bsy);
        exp_t e;
        exp_t o;
        if (adv) exp_phase = exp_phase + 10'd6;
        e.gain  = g;
        e.phase = exp_phase;
        e.ven   = ven;
        e.busy  = bsy;
        e.pal   = exp_pal;
        e.sd    = exp_sd;
        exp_q.push_back(e);
        do_frame();
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
        end else begin
            o = exp_q.pop_front();
            chk({tag, "_gain"},  int'(gain),       int'(o.gain));
            chk({tag, "_phase"}, int'(phase),      int'(o.phase));
            chk({tag, "_ven"},   int'(video_en),   int'(o.ven));
            chk({tag, "_busy"},  int'(busy),       int'(o.busy));
            chk({tag, "_pal"},   int'(pal),        int'(o.pal));
            chk({tag, "_sd"},    int'(scandouble), int'(o.sd));
        end
    endtask

    task automatic fade_in_to_run(input string tag);
        for (int k = 1; k <= 60; k++) expect_frame(tag, 1'b1, 4'(k / 4), 1'b1, 1'b1);
        expect_frame({tag, "_run"}, 1'b1, 4'd15, 1'b1, 1'b0);
    endtask

    initial begin
        reset          = 1'b0;
        ce_pix         = 1'b1;
        VSync          = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        pal_req        = 1'b0;
        scandouble_req = 1'b1;
        exp_phase      = 10'd0;
        exp_pal        = 1'b0;
        exp_sd         = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_gain", int'(gain), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_ven", int'(video_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sd_before_release", int'(scandouble), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("init_sd_loaded", int'(scandouble), 1);
        chk("init_pal_loaded", int'(pal), 0);

        // Fade in from idle: 60 ticks to full gain, phase 360
        start = 1'b1;
        expect_frame("idle_start", 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 60; k++) expect_frame("fade_in", 1'b1, 4'(k / 4), 1'b1, 1'b1);
        chk("fade_in_phase360", int'(phase), 360);
        expect_frame("enter_run", 1'b1, 4'd15, 1'b1, 1'b0);

        // Edge detection: one tick per qualified rising edge only
        @(negedge clk);
        ce_pix = 1'b1;
        VSync  = 1'b1;
        repeat (6) @(negedge clk);
        exp_phase = exp_phase + 10'd6;
        chk("vs_held_one_tick", int'(phase), int'(exp_phase));
        ce_pix = 1'b0;
        for (int i = 0; i < 4; i++) begin
            VSync = ~VSync;
            @(negedge clk);
        end
        chk("vs_toggle_no_ce", int'(phase), int'(exp_phase));
        ce_pix = 1'b1;
        VSync  = 1'b0;
        @(negedge clk);
        ce_pix = 1'b0;
        VSync  = 1'b1;
        repeat (3) @(negedge clk);
        chk("vs_rise_no_ce", int'(phase), int'(exp_phase));
        ce_pix = 1'b1;
        @(negedge clk);
        exp_phase = exp_phase + 10'd6;
        chk("vs_ce_late_tick", int'(phase), int'(exp_phase));
        VSync = 1'b0;
        @(negedge clk);

        // Mode switch: fade out, settle blanked, fade back in
        pal_req = 1'b1;
        expect_frame("run_to_fade_out", 1'b1, 4'd15, 1'b1, 1'b1);
        for (int k = 1; k <= 60; k++) expect_frame("sw_fade_out", 1'b1, 4'(15 - k / 4), 1'b1, 1'b1);
        exp_pal = 1'b1;
        expect_frame("switch_entry", 1'b1, 4'd0, 1'b0, 1'b1);
        expect_frame("switch_settle", 1'b0, 4'd0, 1'b0, 1'b1);
        expect_frame("switch_to_fade_in", 1'b0, 4'd0, 1'b1, 1'b1);
        fade_in_to_run("sw_fade_in");

        // Stop wins over a simultaneous mode request
        stop           = 1'b1;
        scandouble_req = 1'b0;
        expect_frame("stop_run", 1'b1, 4'd15, 1'b1, 1'b1);
        for (int k = 1; k <= 60; k++) expect_frame("stop_fade_out", 1'b1, 4'(15 - k / 4), 1'b1, 1'b1);
        expect_frame("stop_idle", 1'b1, 4'd0, 1'b0, 1'b0);
        expect_frame("idle_hold_stop", 1'b0, 4'd0, 1'b0, 1'b0);

        // Reverse from gain 7 mid fade-in
        stop = 1'b0;
        expect_frame("restart", 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 28; k++) expect_frame("fade_in_7", 1'b1, 4'(k / 4), 1'b1, 1'b1);
        stop = 1'b1;
        expect_frame("reverse", 1'b1, 4'd7, 1'b1, 1'b1);
        for (int k = 1; k <= 28; k++) expect_frame("rev_fade_out", 1'b1, 4'(7 - k / 4), 1'b1, 1'b1);
        expect_frame("rev_idle", 1'b1, 4'd0, 1'b0, 1'b0);
        expect_frame("rev_phase_frozen1", 1'b0, 4'd0, 1'b0, 1'b0);
        expect_frame("rev_phase_frozen2", 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset in the middle of a fade-out
        stop           = 1'b0;
        scandouble_req = 1'b1;
        expect_frame("pre_rst_start", 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) expect_frame("pre_rst_fade_in", 1'b1, 4'(k / 4), 1'b1, 1'b1);
        stop = 1'b1;
        expect_frame("pre_rst_reverse", 1'b1, 4'd2, 1'b1, 1'b1);
        expect_frame("pre_rst_fade_out", 1'b1, 4'd2, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rst_gain", int'(gain), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_ven", int'(video_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_pal", int'(pal), 0);
        chk("async_rst_sd", int'(scandouble), 0);
        stop           = 1'b0;
        start          = 1'b0;
        scandouble_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rerelease_pal", int'(pal), 1);
        chk("rerelease_sd", int'(scandouble), 0);
        chk("rerelease_busy", int'(busy), 0);
        chk("rerelease_gain", int'(gain), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
